// File: rtl/screen_plotter.sv
// ---------------------------------------------------------------------------
// screen_plotter
//
// Purpose:
//   Draws one full picture frame onto the VGA adapter. The block launches the
//   picture source's address sequence and delays the source's raw x/y so that
//   they line up with the registered colour, which arrives LATENCY cycles
//   later. It maps the 2-bit picture colour to a 3-bit VGA colour, strobes
//   plot once per pixel for exactly WIDTH*HEIGHT pixels, and then pulses done
//   for one cycle.
//
// Handshake:
//   start is a level that is sampled only in IDLE. A sampled start launches
//   one frame. start is not queued while busy. busy is high from the LAUNCH
//   cycle through the done cycle. mem_go and done are single-cycle pulses.
//
// Ports:
//   clk         in   system clock
//   resetn      in   asynchronous active-low reset
//   start       in   request one full-frame draw
//   src_x       in   [9:0] raw x from picture source
//   src_y       in   [9:0] raw y from picture source
//   src_colour  in   [1:0] picture colour, LATENCY cycles behind src_x/src_y
//   mem_go      out  one-cycle pulse that launches the source sequence
//   vga_x       out  [7:0] aligned pixel x
//   vga_y       out  [6:0] aligned pixel y
//   vga_colour  out  [2:0] palette-mapped colour
//   plot        out  VGA write strobe
//   busy        out  frame in progress
//   done        out  one-cycle pulse after the last pixel
//   dbg_state   out  [2:0] current FSM state, for observation only
//
// Configuration macro:
//   PLOTTER_SKIP_BLACK_EN - when defined, plot is suppressed for black pixels
//   (src_colour 00), so black is transparent. Frame timing is unchanged.
// ---------------------------------------------------------------------------
module screen_plotter #(
    parameter int WIDTH   = 160,
    parameter int HEIGHT  = 120,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [9:0] src_x,
    input  logic [9:0] src_y,
    input  logic [1:0] src_colour,
    output logic       mem_go,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_FILL   = 3'd2,
        S_PLOT   = 3'd3,
        S_FINISH = 3'd4
    } state_e;

    localparam logic [14:0] PIX_LAST  = 15'(WIDTH * HEIGHT - 1);
    // FILL covers the source latency plus the output register stage, so the
    // first PLOT cycle is the one in which pixel 0 sits on the vga_* outputs.
    localparam logic [2:0]  FILL_LAST = 3'(LATENCY);

    state_e      state_q, state_d;
    logic [2:0]  fill_q, fill_d;
    logic [14:0] pix_q, pix_d;
    logic        plot_en;

    // Only the low bits reach the screen, so the delay lines store them
    // truncated; the discarded upper bits are gathered here.
    logic        unused_src_bits;
    assign unused_src_bits = ^{src_x[9:8], src_y[9:7]};

    logic [7:0]  x_dly_q [LATENCY];
    logic [6:0]  y_dly_q [LATENCY];
    logic [7:0]  vga_x_q;
    logic [6:0]  vga_y_q;
    logic [2:0]  vga_colour_q;

    function automatic logic [2:0] palette(input logic [1:0] c);
        logic [2:0] rgb;
        rgb = 3'b000;
        unique case (c)
            2'b00: rgb = 3'b000;   // black
            2'b01: rgb = 3'b111;   // white
            2'b10: rgb = 3'b100;   // red
            2'b11: rgb = 3'b010;   // green
        endcase
        return rgb;
    endfunction

    // -----------------------------------------------------------------------
    // State and counter registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            fill_q  <= '0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            pix_q   <= pix_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and control outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        pix_d   = pix_q;
        mem_go  = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        plot_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                mem_go  = 1'b1;
                fill_d  = '0;
                pix_d   = '0;
                state_d = S_FILL;
            end
            S_FILL: begin
                if (fill_q == FILL_LAST) begin
                    state_d = S_PLOT;
                end else begin
                    fill_d = fill_q + 3'd1;
                end
            end
            S_PLOT: begin
                plot_en = 1'b1;
                if (pix_q == PIX_LAST) begin
                    state_d = S_FINISH;
                end else begin
                    pix_d = pix_q + 15'd1;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Coordinate delay lines and output registers. After LATENCY stages the
    // coordinates line up with src_colour; one more register stage holds
    // them together with the palette-mapped colour.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < LATENCY; i++) begin
                x_dly_q[i] <= '0;
                y_dly_q[i] <= '0;
            end
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
        end else begin
            x_dly_q[0] <= src_x[7:0];
            y_dly_q[0] <= src_y[6:0];
            for (int i = 1; i < LATENCY; i++) begin
                x_dly_q[i] <= x_dly_q[i-1];
                y_dly_q[i] <= y_dly_q[i-1];
            end
            vga_x_q      <= x_dly_q[LATENCY-1];
            vga_y_q      <= y_dly_q[LATENCY-1];
            vga_colour_q <= palette(src_colour);
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign dbg_state  = state_q;

`ifdef PLOTTER_SKIP_BLACK_EN
    // Only 00 maps to black, so testing the registered colour is enough.
    assign plot = plot_en && (vga_colour_q != 3'b000);
`else
    assign plot = plot_en;
`endif

endmodule

// File: tb/tb_screen_plotter.sv
// ---------------------------------------------------------------------------
// tb_screen_plotter
//
// Bench for screen_plotter. A behavioural picture source answers mem_go with
// a raster x/y sequence and a colour delayed by LAT cycles. Each frame's
// expected plot transactions {x, y, colour} are queued when the frame is
// requested; a monitor pops and compares one entry on every plot strobe.
// ---------------------------------------------------------------------------
module tb_screen_plotter;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int LAT  = 2;
    localparam int NPIX = W * H;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic start  = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic [9:0] src_x;
    logic [9:0] src_y;
    logic [1:0] src_colour;
    logic       mem_go;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;
    logic [2:0] dbg_state;

    screen_plotter #(.WIDTH(W), .HEIGHT(H), .LATENCY(LAT)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .src_x      (src_x),
        .src_y      (src_y),
        .src_colour (src_colour),
        .mem_go     (mem_go),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // ---------------- picture source model ----------------
    int col_mode = 0;   // 0: (x+y)%4, 1: x%2 (alternating black/white)

    function automatic logic [1:0] colour_of(input int mode, input int x, input int y);
        if (mode == 0) return 2'((x + y) % 4);
        return 2'(x % 2);
    endfunction

    logic [9:0] sx = '0;
    logic [9:0] sy = '0;
    logic       src_on = 1'b0;
    logic [1:0] c_pipe [LAT];
    initial for (int i = 0; i < LAT; i++) c_pipe[i] = 2'b00;

    always @(posedge clk) begin
        if (mem_go) begin
            sx     <= '0;
            sy     <= '0;
            src_on <= 1'b1;
        end else if (src_on) begin
            if (sx == 10'(W - 1)) begin
                sx <= '0;
                if (sy == 10'(H - 1)) src_on <= 1'b0;
                else                  sy <= sy + 10'd1;
            end else begin
                sx <= sx + 10'd1;
            end
        end
        c_pipe[0] <= colour_of(col_mode, int'(sx), int'(sy));
        for (int i = 1; i < LAT; i++) c_pipe[i] <= c_pipe[i-1];
    end

    assign src_x      = sx;
    assign src_y      = sy;
    assign src_colour = c_pipe[LAT-1];

    // ---------------- scoreboard ----------------
    logic [17:0] exp_q[$];
    logic [2:0]  pal [4] = '{3'b000, 3'b111, 3'b100, 3'b010};
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Queue the expected plot transactions of one frame; returns how many and
    // the raster index of the first plotted pixel.
    task automatic push_frame(input int mode, output int n, output int first);
        logic [1:0] c;
        n     = 0;
        first = -1;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                c = colour_of(mode, x, y);
`ifdef PLOTTER_SKIP_BLACK_EN
                if (c == 2'b00) continue;
`endif
                if (first < 0) first = y * W + x;
                exp_q.push_back({8'(x), 7'(y), pal[c]});
                n++;
            end
        end
    endtask

    // ---------------- monitor ----------------
    int          plot_cnt      = 0;
    int          mem_go_cnt    = 0;
    int          done_cnt      = 0;
    int          done_plot_cnt = 0;
    int unsigned mem_go_cyc    = 0;
    int unsigned done_cyc      = 0;
    int unsigned first_plot_cyc = 0;
    logic        done_busy     = 1'b0;

    always @(negedge clk) begin
        logic [17:0] e;
        if (resetn) begin
            if (mem_go) begin
                mem_go_cnt++;
                mem_go_cyc = cyc;
            end
            if (plot) begin
                if (plot_cnt == 0) first_plot_cyc = cyc;
                plot_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pixel: plot of %0h with no expected entry (cycle %0d)",
                             {vga_x, vga_y, vga_colour}, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(e));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc      = cyc;
                done_plot_cnt = plot_cnt;
                done_busy     = busy;
                plot_cnt      = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Raise start before an edge; t is the cycle that begins at the sampling edge.
    task automatic start_frame(input logic hold, output int unsigned t);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 t = cyc;
        if (!hold) @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit);
        int i = 0;
        while (done_cnt < target && i < limit) begin
            @(posedge clk);
            i++;
        end
        check("done_seen", 32'(done_cnt >= target), 32'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int          n1, f1, n2, f2, n3, f3, n4, f4, i, d_before, g_before;
        int unsigned t0, t1, t3, t4;

        repeat (3) @(posedge clk);
        @(negedge clk) resetn = 1'b1;

        // Reset asserted mid-cycle clears outputs without a clock edge.
        repeat (2) @(posedge clk);
        #2 resetn = 1'b0;
        #1 check("reset_outputs",
                 32'({mem_go, vga_x, vga_y, vga_colour, plot, busy, done}), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        @(negedge clk) resetn = 1'b1;

        // Idle with start low.
        repeat (100) @(posedge clk);
        check("idle_plot_count", 32'(plot_cnt), 32'd0);
        check("idle_mem_go_count", 32'(mem_go_cnt), 32'd0);

        // Start held high through a frame: one launch per frame, second frame
        // launched as soon as the block is idle again.
        col_mode = 0;
        push_frame(0, n1, f1);
        push_frame(0, n2, f2);
        start_frame(1'b1, t0);
        wait_done(1, NPIX + 50);
        check("f1_mem_go_cycle", mem_go_cyc, t0);
        check("f1_mem_go_count", 32'(mem_go_cnt), 32'd1);
        check("f1_first_plot", first_plot_cyc, t0 + 2 + LAT + f1);
        check("f1_done_cycle", done_cyc, t0 + NPIX + LAT + 2);
        check("f1_plot_count", 32'(done_plot_cnt), 32'(n1));
        check("f1_busy_at_done", 32'(done_busy), 32'd1);

        i = 0;
        while (mem_go_cnt < 2 && i < 10) begin
            @(posedge clk);
            i++;
        end
        check("f2_mem_go_cycle", mem_go_cyc, done_cyc + 2);
        t1 = mem_go_cyc;
        @(negedge clk) start = 1'b0;
        wait_done(2, NPIX + 50);
        check("f2_done_cycle", done_cyc, t1 + NPIX + LAT + 2);
        check("f2_plot_count", 32'(done_plot_cnt), 32'(n2));
        check("f2_mem_go_count", 32'(mem_go_cnt), 32'd2);
        check("f2_queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("f2_busy_after_done", 32'(busy), 32'd0);
        check("f2_done_one_cycle", 32'(done), 32'd0);

        // Reset in the middle of a frame.
        push_frame(0, n3, f3);
        start_frame(1'b0, t3);
        i = 0;
        while (plot_cnt < 5000 && i < 6000) begin
            @(posedge clk);
            i++;
        end
        check("mid_pixel_reached", 32'(plot_cnt >= 5000), 32'd1);
        #1 check("mid_busy_before", 32'(busy), 32'd1);
        #1 resetn = 1'b0;
        #1 check("mid_plot_drop", 32'(plot), 32'd0);
        check("mid_busy_drop", 32'(busy), 32'd0);
        check("mid_done_low", 32'(done), 32'd0);
        exp_q.delete();
        d_before = done_cnt;
        g_before = mem_go_cnt;
        repeat (5) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        repeat (30) @(posedge clk);
        check("mid_no_done", 32'(done_cnt), 32'(d_before));
        check("mid_no_relaunch", 32'(mem_go_cnt), 32'(g_before));
        check("mid_idle_state", 32'(dbg_state), 32'd0);
        plot_cnt = 0;

        // Fresh frame after the reset, alternating black/white pixels.
        col_mode = 1;
        push_frame(1, n4, f4);
        start_frame(1'b0, t4);
        wait_done(d_before + 1, NPIX + 50);
        check("r_mem_go_cycle", mem_go_cyc, t4);
        check("r_first_plot", first_plot_cyc, t4 + 2 + LAT + f4);
        check("r_done_cycle", done_cyc, t4 + NPIX + LAT + 2);
        check("r_plot_count", 32'(done_plot_cnt), 32'(n4));
        check("r_queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("r_busy_after_done", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
